// File: rtl/discrete_derivative_pkg.sv
// discrete_derivative shared types and constants.
// Sample width, saturation limits and the register reset value.
package discrete_derivative_pkg;

  localparam int DATA_W = 8;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic signed [DATA_W:0]   wide_t;

  localparam sample_t SAT_MAX =
    sample_t'((1 << (DATA_W - 1)) - 1);
  localparam sample_t SAT_MIN =
    sample_t'(-(1 << (DATA_W - 1)));
  localparam sample_t PREV_RST = '0;

endpackage

// File: rtl/discrete_derivative_unit_delay.sv
// deriv_unit_delay: enabled one-sample delay register.
// Async active-low clear to PREV_RST; clear beats enable.
module deriv_unit_delay
  import discrete_derivative_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    enb,
  input  sample_t d,
  output sample_t q
);

  // Capture the sample on enabled edges only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= PREV_RST;
    end else if (enb) begin
      q <= d;
    end
  end

endmodule

// File: rtl/discrete_derivative.sv
// discrete_derivative: u = In1 - previous enabled sample.
// DERIV_SAT_EN selects clamping; otherwise the result wraps.
module discrete_derivative
  import discrete_derivative_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  input  logic    enb,
  input  sample_t In1,
  output sample_t u
);

  sample_t prev;
  wide_t   diff;

  deriv_unit_delay u_delay (
    .clk   (clk),
    .reset (reset),
    .enb   (enb),
    .d     (In1),
    .q     (prev)
  );

  // One guard bit keeps the difference exact.
  always_comb begin
    diff = wide_t'(In1) - wide_t'(prev);
  end

`ifdef DERIV_SAT_EN
  // Guard and sign bits disagree only when out of range.
  always_comb begin
    u = sample_t'(diff);
    if (diff[DATA_W] != diff[DATA_W-1]) begin
      u = diff[DATA_W] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  // Keep the low bits: modular wrap.
  always_comb begin
    u = sample_t'(diff);
  end
`endif

endmodule

// File: tb/tb_discrete_derivative.sv
// tb_discrete_derivative: directed checks of the differentiator.
// Expected values follow the build's DERIV_SAT_EN setting.
module tb_discrete_derivative;

  logic              clk;
  logic              reset;
  logic              enb;
  logic signed [7:0] In1;
  logic signed [7:0] u;

  int tests;
  int fails;

  discrete_derivative dut (
    .clk   (clk),
    .reset (reset),
    .enb   (enb),
    .In1   (In1),
    .u     (u)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit hit");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    enb   = 1'b1;
    In1   = 8'sd5;
    #1;
    tests++;
    if (u !== 8'sd5) begin
      fails++;
      $display("FAIL reset_async: u=%0d exp=%0d", u, 5);
    end
    tick();
    tick();
    tests++;
    if (u !== 8'sd5) begin
      fails++;
      $display("FAIL reset_hold: u=%0d exp=%0d", u, 5);
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    tests++;
    if (u !== 8'sd5) begin
      fails++;
      $display("FAIL reset_release: u=%0d exp=%0d", u, 5);
    end
    tick();
    In1 = 8'sd7;
    #1;
    tests++;
    if (u !== 8'sd2) begin
      fails++;
      $display("FAIL reset_first: u=%0d exp=%0d", u, 2);
    end
  endtask

  task automatic test_unit_ramp();
    enb = 1'b1;
    In1 = 8'sd0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      In1 = 8'(i);
      #1;
      tests++;
      if (u !== 8'sd1) begin
        fails++;
        $display("FAIL ramp1_%0d: u=%0d exp=%0d", i, u, 1);
      end
      tick();
    end
    In1 = 8'sd4;
    #1;
    tests++;
    if (u !== 8'sd0) begin
      fails++;
      $display("FAIL ramp1_const: u=%0d exp=%0d", u, 0);
    end
  endtask

  task automatic test_step2_ramp();
    In1 = 8'sd0;
    tick();
    for (int i = 1; i <= 2; i++) begin
      In1 = 8'(2 * i);
      #1;
      tests++;
      if (u !== 8'sd2) begin
        fails++;
        $display("FAIL ramp2_%0d: u=%0d exp=%0d", i, u, 2);
      end
      tick();
    end
    In1 = 8'sd0;
    #1;
    tests++;
    if (u !== -8'sd4) begin
      fails++;
      $display("FAIL ramp2_drop: u=%0d exp=%0d", u, -4);
    end
  endtask

  task automatic test_enable_hold();
    enb = 1'b1;
    In1 = 8'sd10;
    tick();
    enb = 1'b0;
    In1 = 8'sd30;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (u !== 8'sd20) begin
        fails++;
        $display("FAIL hold_%0d: u=%0d exp=%0d", i, u, 20);
      end
    end
    enb = 1'b1;
    tick();
    tests++;
    if (u !== 8'sd0) begin
      fails++;
      $display("FAIL hold_reen: u=%0d exp=%0d", u, 0);
    end
  endtask

  task automatic test_overflow();
    logic signed [7:0] exp_hi;
    logic signed [7:0] exp_lo;
`ifdef DERIV_SAT_EN
    exp_hi = 8'sd127;
    exp_lo = -8'sd128;
`else
    exp_hi = -8'sd1;
    exp_lo = 8'sd1;
`endif
    enb = 1'b1;
    In1 = -8'sd128;
    tick();
    In1 = 8'sd127;
    #1;
    tests++;
    if (u !== exp_hi) begin
      fails++;
      $display("FAIL ovf_pos: u=%0d exp=%0d", u, exp_hi);
    end
    tick();
    In1 = -8'sd128;
    #1;
    tests++;
    if (u !== exp_lo) begin
      fails++;
      $display("FAIL ovf_neg: u=%0d exp=%0d", u, exp_lo);
    end
    In1 = -8'sd1;
    #1;
    tests++;
    if (u !== -8'sd128) begin
      fails++;
      $display("FAIL ovf_edge: u=%0d exp=%0d", u, -128);
    end
    In1 = 8'sd126;
    #1;
    tests++;
    if (u !== -8'sd1) begin
      fails++;
      $display("FAIL ovf_inrange: u=%0d exp=%0d", u, -1);
    end
  endtask

  task automatic test_midstream_reset();
    enb = 1'b1;
    In1 = 8'sd50;
    tick();
    In1 = 8'sd60;
    #1;
    tests++;
    if (u !== 8'sd10) begin
      fails++;
      $display("FAIL mid_before: u=%0d exp=%0d", u, 10);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if (u !== 8'sd60) begin
      fails++;
      $display("FAIL mid_assert: u=%0d exp=%0d", u, 60);
    end
    #2;
    reset = 1'b1;
    #1;
    tests++;
    if (u !== 8'sd60) begin
      fails++;
      $display("FAIL mid_release: u=%0d exp=%0d", u, 60);
    end
    tick();
    tests++;
    if (u !== 8'sd0) begin
      fails++;
      $display("FAIL mid_reload: u=%0d exp=%0d", u, 0);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b0;
    enb   = 1'b0;
    In1   = '0;
    test_reset();
    test_unit_ramp();
    test_step2_ramp();
    test_enable_hold();
    test_overflow();
    test_midstream_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
